dmem_responder: RTL and testbench

Data-memory responder on the far side of the MEM stage's data-memory port. It accepts one sized load or store per request over a valid/ready handshake and applies programmable wait states. It performs byte-lane steering into word-organised storage and returns right-aligned, zero-extended read data; WB performs sign extension. Misaligned or illegal-size accesses are rejected without touching storage.

---
 rtl/dmem_responder.sv | 197 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: sized loads/stores over valid/ready with programmable wait states.
// Loads return right-aligned, zero-extended data; misaligned or illegal sizes are rejected.
module dmem_responder #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] addr_i,
  input  logic        wr_enable_i,
  input  logic [1:0]  rd_size_i,
  input  logic [1:0]  wr_size_i,
  input  logic [31:0] wr_data_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] rd_data_o,
  output logic        misaligned_o,
  output logic        busy_o
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned WORDS = 2 ** IDX_W;
  localparam int unsigned CNT_W = 4;
  localparam bit          ZERO_LAT = (LATENCY == 0);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [1:0]          size_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q, rdata_d;
  logic                mis_q, mis_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                latch_c;

  logic [31:0]         mem_q [WORDS];

  logic [1:0]          in_size_c;
  logic                in_err_c;
  logic [ADDR_W-1:0]   acc_addr_c;
  logic                acc_we_c;
  logic [1:0]          acc_size_c;
  logic [31:0]         acc_wdata_c;
  logic [IDX_W-1:0]    acc_idx_c;
  logic [4:0]          acc_shift_c;
  logic [31:0]         shifted_c;
  logic [31:0]         load_c;
  logic [3:0]          be_c;
  logic [31:0]         wd_c;
  logic                do_access_c;
  logic                mem_we_c;
  logic                unused_addr_c;

  function automatic logic is_err(input logic [1:0] sz, input logic [1:0] lane);
    return (sz == 2'b11) || ((sz == SIZE_HALF) && lane[0]) ||
           ((sz == SIZE_WORD) && (lane != 2'b00));
  endfunction

  assign unused_addr_c = ^addr_i[31:ADDR_W];

  // With zero latency the access happens on the accept edge, so it uses the live inputs.
  assign in_size_c   = wr_enable_i ? wr_size_i : rd_size_i;
  assign in_err_c    = is_err(in_size_c, addr_i[1:0]);
  assign acc_addr_c  = (state_q == S_IDLE) ? addr_i[ADDR_W-1:0] : addr_q;
  assign acc_we_c    = (state_q == S_IDLE) ? wr_enable_i : we_q;
  assign acc_size_c  = (state_q == S_IDLE) ? in_size_c : size_q;
  assign acc_wdata_c = (state_q == S_IDLE) ? wr_data_i : wdata_q;
  assign acc_idx_c   = acc_addr_c[ADDR_W-1:2];
  assign acc_shift_c = {acc_addr_c[1:0], 3'b000};
  assign shifted_c   = mem_q[acc_idx_c] >> acc_shift_c;
  assign wd_c        = acc_wdata_c << acc_shift_c;

  always_comb begin
    load_c = shifted_c;
    be_c   = 4'b1111;
    case (acc_size_c)
      SIZE_BYTE: begin
        load_c = {24'd0, shifted_c[7:0]};
        be_c   = 4'b0001 << acc_addr_c[1:0];
      end
      SIZE_HALF: begin
        load_c = {16'd0, shifted_c[15:0]};
        be_c   = 4'b0011 << acc_addr_c[1:0];
      end
      default: ;
    endcase
  end

  assign do_access_c = ((state_q == S_IDLE) && req_valid_i && !in_err_c && ZERO_LAT) ||
                       ((state_q == S_WAIT) && (cnt_q == '0));
  assign mem_we_c    = do_access_c && acc_we_c && reset_n_i;

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    latch_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          latch_c = 1'b1;
          if (in_err_c) begin
            state_d = S_RESP;
            mis_d   = 1'b1;
            rdata_d = '0;
          end else if (ZERO_LAT) begin
            state_d = S_RESP;
            mis_d   = 1'b0;
            rdata_d = acc_we_c ? 32'd0 : load_c;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          mis_d   = 1'b0;
          rdata_d = acc_we_c ? 32'd0 : load_c;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
          rdata_d = '0;
          mis_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_RESP);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      if (latch_c) begin
        addr_q  <= addr_i[ADDR_W-1:0];
        we_q    <= wr_enable_i;
        size_q  <= in_size_c;
        wdata_q <= wr_data_i;
      end
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk_i) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem_q[acc_idx_c][8*b +: 8] <= wd_c[8*b +: 8];
      end
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = valid_q;
  assign rd_data_o    = rdata_q;
  assign misaligned_o = mis_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: four instances at LATENCY 1, 4, 0 and 15.
module tb_dmem_responder;

  logic             clk;
  logic [3:0]       rst_n;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][31:0] addr;
  logic [3:0]       wr_en;
  logic [3:0][1:0]  rd_size;
  logic [3:0][1:0]  wr_size;
  logic [3:0][31:0] wdata;
  logic [3:0]       resp_valid;
  logic [3:0]       resp_ready;
  logic [3:0][31:0] rd_data;
  logic [3:0]       misaligned;
  logic [3:0]       busy;

  int pass_cnt = 0;
  int total    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 0 : 15;
    dmem_responder #(.ADDR_W(16), .LATENCY(LAT)) u_dut (
      .clk_i        (clk),
      .reset_n_i    (rst_n[g]),
      .req_valid_i  (req_valid[g]),
      .req_ready_o  (req_ready[g]),
      .addr_i       (addr[g]),
      .wr_enable_i  (wr_en[g]),
      .rd_size_i    (rd_size[g]),
      .wr_size_i    (wr_size[g]),
      .wr_data_i    (wdata[g]),
      .resp_valid_o (resp_valid[g]),
      .resp_ready_i (resp_ready[g]),
      .rd_data_o    (rd_data[g]),
      .misaligned_o (misaligned[g]),
      .busy_o       (busy[g])
    );
  end

  // One request on instance k; lat counts edges after the accept edge until resp_valid.
  task automatic xact(input int k, input bit we, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic mis, output int lat);
    @(posedge clk); #1;
    req_valid[k] = 1'b1;
    wr_en[k]     = we;
    addr[k]      = a;
    wdata[k]     = d;
    rd_size[k]   = we ? 2'b11 : sz;
    wr_size[k]   = we ? sz : 2'b11;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    lat = 0;
    while (!resp_valid[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid[k]) lat = -1;
    rd  = rd_data[k];
    mis = misaligned[k];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (req_ready[k] !== 1'b1 || resp_valid[k] !== 1'b0 || rd_data[k] !== 32'd0 ||
          misaligned[k] !== 1'b0 || busy[k] !== 1'b0)
        $display("FAIL reset[%0d]: rdy=%b vld=%b rd=%h mis=%b busy=%b, want 1 0 0 0 0",
                 k, req_ready[k], resp_valid[k], rd_data[k], misaligned[k], busy[k]);
      else pass_cnt++;
    end
    rst_n = 4'hF;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic mis; int lat;
    xact(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, rd, mis, lat);
    total++;
    if (lat !== 1 || rd !== 32'd0 || mis !== 1'b0)
      $display("FAIL sw_word: lat=%0d rd=%h mis=%b, want 1 00000000 0", lat, rd, mis);
    else pass_cnt++;
    xact(0, 1'b0, 2'b10, 32'h10, 32'h0, rd, mis, lat);
    total++;
    if (lat !== 1 || rd !== 32'hDEADBEEF || mis !== 1'b0)
      $display("FAIL lw_word: lat=%0d rd=%h mis=%b, want 1 deadbeef 0", lat, rd, mis);
    else pass_cnt++;
  endtask

  task automatic test_lanes();
    logic [31:0] rd; logic mis; int lat;
    xact(0, 1'b1, 2'b00, 32'h12, 32'hAAAAAA55, rd, mis, lat);
    xact(0, 1'b0, 2'b10, 32'h10, 32'h0, rd, mis, lat);
    total++;
    if (rd !== 32'hDE55BEEF) $display("FAIL sb_then_lw: rd=%h want de55beef", rd);
    else pass_cnt++;
    xact(0, 1'b0, 2'b00, 32'h13, 32'h0, rd, mis, lat);
    total++;
    if (rd !== 32'h000000DE) $display("FAIL lbu_13: rd=%h want 000000de", rd);
    else pass_cnt++;
    xact(0, 1'b0, 2'b01, 32'h12, 32'h0, rd, mis, lat);
    total++;
    if (rd !== 32'h0000DE55) $display("FAIL lhu_12: rd=%h want 0000de55", rd);
    else pass_cnt++;
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic mis; int lat;
    xact(0, 1'b0, 2'b10, 32'h11, 32'h0, rd, mis, lat);
    total++;
    if (lat !== 0 || mis !== 1'b1 || rd !== 32'd0)
      $display("FAIL lw_11: lat=%0d mis=%b rd=%h, want 0 1 00000000", lat, mis, rd);
    else pass_cnt++;
    xact(0, 1'b1, 2'b01, 32'h13, 32'h0000FFFF, rd, mis, lat);
    total++;
    if (lat !== 0 || mis !== 1'b1) $display("FAIL sh_13: lat=%0d mis=%b, want 0 1", lat, mis);
    else pass_cnt++;
    xact(0, 1'b0, 2'b10, 32'h10, 32'h0, rd, mis, lat);
    total++;
    if (rd !== 32'hDE55BEEF || mis !== 1'b0)
      $display("FAIL after_sh_13: rd=%h mis=%b, want de55beef 0", rd, mis);
    else pass_cnt++;
    xact(0, 1'b0, 2'b11, 32'h10, 32'h0, rd, mis, lat);
    total++;
    if (mis !== 1'b1 || rd !== 32'd0) $display("FAIL size_11: mis=%b rd=%h, want 1 0", mis, rd);
    else pass_cnt++;
    xact(0, 1'b0, 2'b01, 32'h11, 32'h0, rd, mis, lat);
    total++;
    if (mis !== 1'b1) $display("FAIL lh_11: mis=%b want 1", mis);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic mis; int lat; int errs; int wait_cyc;
    resp_ready[0] = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b1; wr_en[0] = 1'b0; addr[0] = 32'h10;
    rd_size[0] = 2'b10; wr_size[0] = 2'b11;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_cyc = 0;
    while (!resp_valid[0] && wait_cyc < 40) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    errs = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        req_valid[0] = 1'b1; wr_en[0] = 1'b1; addr[0] = 32'h10;
        wdata[0] = 32'h0; wr_size[0] = 2'b10;
      end else begin
        req_valid[0] = 1'b0;
      end
      if (resp_valid[0] !== 1'b1 || rd_data[0] !== 32'hDE55BEEF ||
          req_ready[0] !== 1'b0 || busy[0] !== 1'b1) errs++;
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    total++;
    if (errs != 0) $display("FAIL backpressure_hold: %0d unstable cycles, want 0", errs);
    else pass_cnt++;
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    total++;
    if (resp_valid[0] !== 1'b0 || rd_data[0] !== 32'd0 || req_ready[0] !== 1'b1)
      $display("FAIL backpressure_release: vld=%b rd=%h rdy=%b, want 0 0 1",
               resp_valid[0], rd_data[0], req_ready[0]);
    else pass_cnt++;
    xact(0, 1'b0, 2'b10, 32'h10, 32'h0, rd, mis, lat);
    total++;
    if (rd !== 32'hDE55BEEF) $display("FAIL pulse_ignored: rd=%h want de55beef", rd);
    else pass_cnt++;
  endtask

  task automatic test_reset_wait();
    logic [31:0] rd; logic mis; int lat;
    @(posedge clk); #1;
    req_valid[1] = 1'b1; wr_en[1] = 1'b1; addr[1] = 32'h20;
    wdata[1] = 32'h12345678; wr_size[1] = 2'b10; rd_size[1] = 2'b11;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    total++;
    if (busy[1] !== 1'b1 || req_ready[1] !== 1'b0 || resp_valid[1] !== 1'b0)
      $display("FAIL wait_state: busy=%b rdy=%b vld=%b, want 1 0 0", busy[1], req_ready[1], resp_valid[1]);
    else pass_cnt++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    #1;
    total++;
    if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0 || rd_data[1] !== 32'd0 ||
        misaligned[1] !== 1'b0 || busy[1] !== 1'b0)
      $display("FAIL reset_mid_wait: rdy=%b vld=%b rd=%h mis=%b busy=%b, want 1 0 0 0 0",
               req_ready[1], resp_valid[1], rd_data[1], misaligned[1], busy[1]);
    else pass_cnt++;
    repeat (6) @(posedge clk);
    #1;
    rst_n[1] = 1'b1;
    xact(1, 1'b0, 2'b10, 32'h20, 32'h0, rd, mis, lat);
    total++;
    if (lat !== 4 || rd === 32'h12345678)
      $display("FAIL store_discarded: lat=%0d rd=%h, want 4 and not 12345678", lat, rd);
    else pass_cnt++;
  endtask

  task automatic test_latency_alias();
    logic [31:0] rd; logic mis; int lat;
    xact(2, 1'b1, 2'b10, 32'h8, 32'hCAFEF00D, rd, mis, lat);
    total++;
    if (lat !== 0) $display("FAIL lat0_sw: lat=%0d want 0", lat);
    else pass_cnt++;
    xact(2, 1'b0, 2'b10, 32'h8, 32'h0, rd, mis, lat);
    total++;
    if (lat !== 0 || rd !== 32'hCAFEF00D) $display("FAIL lat0_lw: lat=%0d rd=%h, want 0 cafef00d", lat, rd);
    else pass_cnt++;
    xact(3, 1'b1, 2'b10, 32'h4, 32'h01020304, rd, mis, lat);
    total++;
    if (lat !== 15) $display("FAIL lat15_sw: lat=%0d want 15", lat);
    else pass_cnt++;
    xact(3, 1'b0, 2'b01, 32'h6, 32'h0, rd, mis, lat);
    total++;
    if (lat !== 15 || rd !== 32'h00000102) $display("FAIL lat15_lhu: lat=%0d rd=%h, want 15 00000102", lat, rd);
    else pass_cnt++;
    xact(3, 1'b0, 2'b11, 32'h4, 32'h0, rd, mis, lat);
    total++;
    if (lat !== 0 || mis !== 1'b1) $display("FAIL lat15_err: lat=%0d mis=%b, want 0 1", lat, mis);
    else pass_cnt++;
    xact(0, 1'b1, 2'b10, 32'h0001_0004, 32'h0BADF00D, rd, mis, lat);
    xact(0, 1'b0, 2'b10, 32'h0000_0004, 32'h0, rd, mis, lat);
    total++;
    if (rd !== 32'h0BADF00D) $display("FAIL alias: rd=%h want 0badf00d", rd);
    else pass_cnt++;
  endtask

  initial begin
    rst_n      = 4'h0;
    req_valid  = '0;
    addr       = '0;
    wr_en      = '0;
    rd_size    = '0;
    wr_size    = '0;
    wdata      = '0;
    resp_ready = 4'hF;
    test_reset();
    test_word();
    test_lanes();
    test_misaligned();
    test_backpressure();
    test_reset_wait();
    test_latency_alias();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
